tt_sweep: RTL and testbench
===========================

TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 Parameter: SETTLE, default 1, number of cycles (1..15) each input vector is held before the output is sampled.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request a full 16-vector sweep; honoured only in IDLE.
REQ-005 Port: expect  input  16  golden truth table, bit i = expected f for vector i; sampled on accepted start.
REQ-006 Port: f_in  input  1  combinational output of the 4-input function under test.
REQ-007 Port: a, b, c, d  output  1 each  registered drive to the function under test; {a,b,c,d} = vector index, a = MSB.
REQ-008 Port: tt  output  16  captured truth table, bit i = f_in sampled for vector i.
REQ-009 Port: busy  output  1  high while a sweep is in progress.
REQ-010 Port: done  output  1  high from sweep completion until the next accepted start.
REQ-011 Port: pass  output  1  valid when done: captured table equals sampled expect.
REQ-012 Port: fail_idx  output  4  lowest vector index whose captured bit differs from expect; 0 when pass.

Function
REQ-013 FSM states: IDLE, DRIVE, SAMPLE, FIN.
REQ-014 IDLE with start=1: latch expect, clear tt, set index=0, clear done, enter DRIVE next cycle.
REQ-015 start while busy or in FIN-to-IDLE transition cycle is ignored; no restart mid-sweep.
REQ-016 DRIVE: a..d = index; settle counter runs SETTLE cycles, then enter SAMPLE.
REQ-017 SAMPLE (one cycle): tt[index] <= f_in; compare with expect[index]; record index in fail_idx on first mismatch only.
REQ-018 SAMPLE with index<15: index+1, settle counter cleared, return to DRIVE.
REQ-019 SAMPLE with index=15: enter FIN; no wrap of index beyond 15.
REQ-020 FIN (one cycle): done=1, pass=(no mismatch recorded), busy=0, then IDLE; done/pass/tt/fail_idx held until next accepted start.
REQ-021 Latency, start accepted at cycle 0: done first high at cycle 16*(SETTLE+1)+1.
REQ-022 busy = 1 in DRIVE and SAMPLE only.
REQ-023 a..d hold last driven vector in IDLE/FIN.
REQ-024 f_in is sampled only in SAMPLE; changes elsewhere have no effect.

Reset
REQ-025 rst=1 forces, immediately and asynchronously: state IDLE, index 0, a=b=c=d=0, tt=0, busy=0, done=0, pass=0, fail_idx=0, latched expect=0.
REQ-026 rst asserted mid-sweep aborts it; no partial done/pass is produced; after release, block waits in IDLE for start.

Configuration
REQ-027 Macro TT_SWEEP_STOP_ON_FAIL_EN defined: first mismatch in SAMPLE goes directly to FIN with pass=0, fail_idx=index; untested tt bits remain 0.
REQ-028 Macro undefined: all 16 vectors always swept; fail_idx still reports first mismatch; latency per REQ-021 fixed.

Structure
REQ-029 Shared package tt_pkg holds: FSM state enum (IDLE, DRIVE, SAMPLE, FIN), vector width constant (4), table size constant (16).
REQ-030 One sub-module tt_settle_cnt: 4-bit settle counter with clear and terminal-count output at SETTLE; FSM and capture logic stay in tt_sweep.

Verification
REQ-031 Function under test f = majority of {a,b,c} (table 16'hFCC0 style golden), expect matching, SETTLE=1, start pulse -> done at cycle 33, pass=1, tt=expect, fail_idx=0.
REQ-032 expect with bit 5 flipped vs real table -> pass=0, fail_idx=5; without macro tt = true table, done at cycle 33.
REQ-033 Same as REQ-032 with TT_SWEEP_STOP_ON_FAIL_EN -> FIN after vector 5, done at cycle 6*(SETTLE+1)+1=13, tt bits 15..6 = 0.
REQ-034 start re-pulsed at cycles 5 and 20 during sweep -> ignored, single done at cycle 33.
REQ-035 rst pulsed at cycle 10 mid-sweep -> all outputs 0 immediately, done stays 0, new start after release gives normal result.
REQ-036 SETTLE=3, f_in = d -> done at cycle 65, tt=16'hAAAA, a..d step 0..15 with each vector held 3 cycles plus sample cycle.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types and sizes for the truth-table sweep block.
package tt_pkg;
   localparam int VEC_W = 4;   // inputs of the function under test
   localparam int TBL_N = 16;  // rows in a 4-input truth table

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      FIN
   } state_t;
endpackage

// File: rtl/tt_settle_cnt.sv
// Settle counter: counts the cycles a vector has been driven and flags the
// last settle cycle (count == SETTLE-1, i.e. SETTLE cycles elapsed once the
// flag is seen). Holds at the terminal value until cleared.
module tt_settle_cnt #(
   parameter int SETTLE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam logic [3:0] LAST = 4'(SETTLE - 1);

   logic [3:0] cnt_q, cnt_d;

   assign tc = (cnt_q == LAST);

   // Next count: clear wins, otherwise advance while enabled until terminal.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !tc) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/tt_sweep.sv
// Truth-table sweeper: drives all 16 input vectors of a 4-input function,
// captures its output per vector and compares against a golden table latched
// at start (expect_tt). Optional build macro TT_SWEEP_STOP_ON_FAIL_EN ends the
// sweep at the first mismatching vector instead of sweeping all 16.
module tt_sweep
   import tt_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [TBL_N-1:0] expect_tt,
   input  logic             f_in,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             d,
   output logic [TBL_N-1:0] tt,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [VEC_W-1:0] fail_idx
);
   localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(TBL_N - 1);

   state_t             state_q, state_d;
   logic [VEC_W-1:0]   idx_q, idx_d;
   logic [TBL_N-1:0]   exp_q, exp_d;
   logic [TBL_N-1:0]   tt_q, tt_d;
   logic               done_q, done_d;
   logic               pass_q, pass_d;
   logic [VEC_W-1:0]   fail_q, fail_d;
   logic               mism_q, mism_d;
   logic               hit;
   logic               stop;
   logic               settle_tc;

   tt_settle_cnt #(.SETTLE(SETTLE)) u_settle (
      .clk (clk),
      .rst (rst),
      .clr (state_q != DRIVE),
      .en  (state_q == DRIVE),
      .tc  (settle_tc)
   );

   // Sweep sequencing, capture and compare; results hold until next start.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      exp_d   = exp_q;
      tt_d    = tt_q;
      done_d  = done_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      mism_d  = mism_q;
      hit     = 1'b0;
      stop    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               exp_d   = expect_tt;
               tt_d    = '0;
               idx_d   = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               fail_d  = '0;
               mism_d  = 1'b0;
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (settle_tc) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            tt_d[idx_q] = f_in;
            hit = (f_in != exp_q[idx_q]);
            if (hit && !mism_q) begin
               mism_d = 1'b1;
               fail_d = idx_q;
            end
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
            stop = hit;
`else
            stop = 1'b0;
`endif
            if (stop || (idx_q == LAST_IDX)) begin
               state_d = FIN;
            end else begin
               idx_d   = idx_q + VEC_W'(1);
               state_d = DRIVE;
            end
         end
         FIN: begin
            done_d  = 1'b1;
            pass_d  = !mism_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers, all cleared by asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         exp_q   <= '0;
         tt_q    <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= '0;
         mism_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         exp_q   <= exp_d;
         tt_q    <= tt_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         mism_q  <= mism_d;
      end
   end

   assign {a, b, c, d} = idx_q;
   assign tt           = tt_q;
   assign busy         = (state_q == DRIVE) || (state_q == SAMPLE);
   assign done         = done_q;
   assign pass         = pass_q;
   assign fail_idx     = fail_q;
endmodule

// File: tb/tb_tt_sweep.sv
// Directed bench for tt_sweep: one instance with SETTLE=1 sweeping a
// 3-input majority function, one with SETTLE=3 sweeping f = d.
module tb_tt_sweep;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0;
   logic        start1 = 1'b0, start3 = 1'b0;
   logic [15:0] exp1 = '0, exp3 = '0;
   logic        a1, b1, c1, d1, f1, busy1, done1, pass1;
   logic        a3, b3, c3, d3, f3, busy3, done3, pass3;
   logic [15:0] tt1, tt3;
   logic [3:0]  fi1, fi3;

   int n_assert = 0;
   int n_fail   = 0;
   int dcyc;
   bit saw;

   localparam logic [15:0] MAJ = 16'hFCC0;

   assign f1 = (a1 & b1) | (a1 & c1) | (b1 & c1);
   assign f3 = d3;

   tt_sweep #(.SETTLE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .expect_tt(exp1), .f_in(f1),
      .a(a1), .b(b1), .c(c1), .d(d1), .tt(tt1), .busy(busy1),
      .done(done1), .pass(pass1), .fail_idx(fi1)
   );

   tt_sweep #(.SETTLE(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .expect_tt(exp3), .f_in(f3),
      .a(a3), .b(b3), .c(c3), .d(d3), .tt(tt3), .busy(busy3),
      .done(done3), .pass(pass3), .fail_idx(fi3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start a sweep on dut1 (accepted at edge 0) and return the cycle at
   // which done first reads high; optionally re-pulse start at cycles 5, 20.
   task automatic run1(input logic [15:0] ex, input bit repulse, output int dc);
      @(negedge clk);
      exp1   = ex;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      chk("busy_after_start", 32'(busy1), 1);
      chk("done_cleared_on_start", 32'(done1), 0);
      dc = -1;
      for (int cy = 1; cy <= 200; cy++) begin
         start1 = repulse && (cy == 5 || cy == 20);
         @(posedge clk); #1;
         if (done1) begin
            dc = cy;
            break;
         end
      end
      start1 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Asynchronous reset, checked before any clock edge.
      #2 rst = 1'b1;
      #1;
      chk("rst_tt", 32'(tt1), 0);
      chk("rst_vec", 32'({a1, b1, c1, d1}), 0);
      chk("rst_busy", 32'(busy1), 0);
      chk("rst_done", 32'(done1), 0);
      chk("rst_pass", 32'(pass1), 0);
      chk("rst_fail_idx", 32'(fi1), 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      // Matching golden table: full pass.
      run1(MAJ, 1'b0, dcyc);
      chk("maj_done_cycle", dcyc, 33);
      chk("maj_pass", 32'(pass1), 1);
      chk("maj_tt", 32'(tt1), 32'(MAJ));
      chk("maj_fail_idx", 32'(fi1), 0);
      chk("maj_busy_idle", 32'(busy1), 0);
      chk("maj_vec_hold", 32'({a1, b1, c1, d1}), 15);
      @(posedge clk); #1;
      chk("maj_done_held", 32'(done1), 1);

      // Golden table with bit 5 wrong.
      run1(MAJ ^ 16'h0020, 1'b0, dcyc);
      chk("bad5_pass", 32'(pass1), 0);
      chk("bad5_fail_idx", 32'(fi1), 5);
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
      chk("bad5_done_cycle", dcyc, 13);
      chk("bad5_tt", 32'(tt1), 0);
      chk("bad5_vec_hold", 32'({a1, b1, c1, d1}), 5);
`else
      chk("bad5_done_cycle", dcyc, 33);
      chk("bad5_tt", 32'(tt1), 32'(MAJ));
      chk("bad5_vec_hold", 32'({a1, b1, c1, d1}), 15);
`endif

      // Start re-pulsed mid-sweep must be ignored.
      run1(MAJ, 1'b1, dcyc);
      chk("repulse_done_cycle", dcyc, 33);
      chk("repulse_pass", 32'(pass1), 1);
      chk("repulse_tt", 32'(tt1), 32'(MAJ));

      // Reset in the middle of a sweep.
      @(negedge clk);
      exp1   = MAJ;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      chk("midrst_vec_before", 32'({a1, b1, c1, d1}), 5);
      chk("midrst_busy_before", 32'(busy1), 1);
      rst = 1'b1;
      #1;
      chk("midrst_vec", 32'({a1, b1, c1, d1}), 0);
      chk("midrst_busy", 32'(busy1), 0);
      chk("midrst_tt", 32'(tt1), 0);
      chk("midrst_done", 32'(done1), 0);
      chk("midrst_pass", 32'(pass1), 0);
      chk("midrst_fail_idx", 32'(fi1), 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      saw = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done1 || busy1) saw = 1'b1;
      end
      chk("midrst_stays_idle", 32'(saw), 0);
      run1(MAJ, 1'b0, dcyc);
      chk("after_rst_done_cycle", dcyc, 33);
      chk("after_rst_pass", 32'(pass1), 1);
      chk("after_rst_tt", 32'(tt1), 32'(MAJ));

      // SETTLE=3 instance with f = d.
      @(negedge clk);
      exp3   = 16'hAAAA;
      start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      dcyc = -1;
      for (int cy = 0; cy <= 200; cy++) begin
         if (cy > 0) begin
            @(posedge clk); #1;
         end
         if (cy < 64) chk("s3_vec_step", 32'({a3, b3, c3, d3}), cy / 4);
         if (cy == 64) chk("s3_busy_fin", 32'(busy3), 0);
         if (done3) begin
            dcyc = cy;
            break;
         end
      end
      chk("s3_done_cycle", dcyc, 65);
      chk("s3_tt", 32'(tt3), 32'hAAAA);
      chk("s3_pass", 32'(pass3), 1);
      chk("s3_fail_idx", 32'(fi3), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
